// File: rtl/stdp_learning_engine_if.sv
// Port bundle for stdp_learning_engine: spike inputs, weight readback and update stream.
// The engine connects through the slave modport; the SNN core side uses master.
interface stdp_learning_engine_if #(
    parameter int N_PRE      = 16,
    parameter int HIST_DEPTH = 8,
    parameter int W_WIDTH    = 4
);
    localparam int CW  = $clog2(N_PRE);
    localparam int DTW = $clog2(HIST_DEPTH) + 1;

    logic                      learn_en;
    logic [N_PRE-1:0]          pre_spike;
    logic                      post_spike;
    logic [CW-1:0]             rd_sel;
    logic [W_WIDTH-1:0]        rd_weight;
    logic                      busy;
    logic                      upd_valid;
    logic [CW-1:0]             upd_ch;
    logic signed [DTW-1:0]     upd_dt;
    logic [W_WIDTH-1:0]        upd_weight;
    logic                      post_ovf;

    modport master (
        output learn_en, pre_spike, post_spike, rd_sel,
        input  rd_weight, busy, upd_valid, upd_ch, upd_dt, upd_weight, post_ovf
    );

    modport slave (
        input  learn_en, pre_spike, post_spike, rd_sel,
        output rd_weight, busy, upd_valid, upd_ch, upd_dt, upd_weight, post_ovf
    );
endinterface

// File: rtl/stdp_learning_engine.sv
// STDP weight-update engine: post events sweep LTP, pre events sweep LTD, one channel per clock.
// Define STDP_LTD_EN to build pre-event capture and the LTD sweep; otherwise LTP only.
module stdp_learning_engine #(
    parameter int N_PRE      = 16,
    parameter int HIST_DEPTH = 8,
    parameter int W_WIDTH    = 4,
    parameter int W_INIT     = 8,
    parameter int NEAR_WIN   = 2
) (
    input logic                   clock,
    input logic                   reset,
    stdp_learning_engine_if.slave bus
);
    localparam int D   = HIST_DEPTH;
    localparam int CW  = $clog2(N_PRE);
    localparam int KW  = $clog2(D);
    localparam int DTW = KW + 1;

    typedef enum logic [1:0] {IDLE, LTP_SCAN, LTD_SCAN} state_t;

    state_t                      state, stateNxt;
    logic [CW-1:0]               ch;
    logic [N_PRE-1:0][D-2:0]     preHist;
    logic [D-2:0]                postHist;
    logic [N_PRE-1:0][D-1:0]     preWin;
    logic [D-1:0]                postWin;
    logic [N_PRE-1:0][D-1:0]     postSlot;
    logic [N_PRE-1:0][D-1:0]     snap;
    logic                        slotFull;
    logic                        slotTake;
    logic                        postCap;
    logic                        anyPending;
    logic [N_PRE-1:0][W_WIDTH-1:0] weight;

    logic [KW-1:0]               curK;
    logic [KW-1:0]               curMag;
    logic                        ltpHit;
    logic                        ltdHit;
    logic [1:0]                  step;
    logic [W_WIDTH:0]            wCur;
    logic [W_WIDTH:0]            stepExt;
    logic [W_WIDTH:0]            sum;
    logic [W_WIDTH:0]            diff;
    logic [W_WIDTH-1:0]          newW;
    logic [DTW-1:0]              magExt;
    logic [DTW-1:0]              dtOut;

`ifdef STDP_LTD_EN
    logic [N_PRE-1:0]            pending;
    logic [N_PRE-1:0][KW-1:0]    ltdK;
    logic [KW-1:0]               postK;
`endif

    // Smallest k in 1..D-1 with win[k] set; 0 means none (bit 0 is simultaneous and never counts).
    function automatic logic [KW-1:0] firstK(input logic [D-1:0] win);
        logic [KW-1:0] r;
        r = '0;
        for (int k = D - 1; k >= 1; k--)
            if (win[k]) r = KW'(k);
        return r;
    endfunction

    for (genvar i = 0; i < N_PRE; i++) begin : g_win
        assign preWin[i] = {preHist[i], bus.pre_spike[i]};
    end
    assign postWin = {postHist, bus.post_spike};

    assign postCap  = bus.post_spike & bus.learn_en;
    assign slotTake = (state == IDLE) && slotFull;

    // Histories and the single-entry post slot; the slot may refill on the edge it drains.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            preHist      <= '0;
            postHist     <= '0;
            postSlot     <= '0;
            snap         <= '0;
            slotFull     <= 1'b0;
            bus.post_ovf <= 1'b0;
        end else begin
            for (int i = 0; i < N_PRE; i++) preHist[i] <= preWin[i][D-2:0];
            postHist <= postWin[D-2:0];
            if (slotTake) snap <= postSlot;
            if (postCap && (!slotFull || slotTake)) begin
                postSlot <= preWin;
                slotFull <= 1'b1;
            end else if (slotTake) begin
                slotFull <= 1'b0;
            end
            if (postCap && slotFull && !slotTake) bus.post_ovf <= 1'b1;
        end
    end

`ifdef STDP_LTD_EN
    assign postK = firstK(postWin);

    // A fresh capture beats the clear issued by the LTD sweep on the same edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pending <= '0;
            ltdK    <= '0;
        end else begin
            for (int i = 0; i < N_PRE; i++) begin
                if (bus.learn_en && bus.pre_spike[i] && (postK != '0)) begin
                    pending[i] <= 1'b1;
                    ltdK[i]    <= postK;
                end else if (ltdHit && (ch == CW'(i))) begin
                    pending[i] <= 1'b0;
                end
            end
        end
    end
    assign anyPending = |pending;
`else
    assign anyPending = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= stateNxt;
    end

    always_comb begin
        stateNxt = state;
        case (state)
            IDLE: begin
                if (slotFull)        stateNxt = LTP_SCAN;
                else if (anyPending) stateNxt = LTD_SCAN;
            end
            LTP_SCAN, LTD_SCAN: begin
                if (ch == CW'(N_PRE - 1)) stateNxt = IDLE;
            end
            default: stateNxt = IDLE;
        endcase
    end

    // Per-channel step and saturating read-modify-write for the channel under the sweep.
    always_comb begin
        curK   = firstK(snap[ch]);
        ltpHit = (state == LTP_SCAN) && (curK != '0);
        ltdHit = 1'b0;
        curMag = curK;
`ifdef STDP_LTD_EN
        if (state == LTD_SCAN) begin
            ltdHit = pending[ch];
            curMag = ltdK[ch];
        end
`endif
        step    = (int'(curMag) <= NEAR_WIN) ? 2'd2 : 2'd1;
        wCur    = {1'b0, weight[ch]};
        stepExt = (W_WIDTH + 1)'(step);
        sum     = wCur + stepExt;
        diff    = wCur - stepExt;
        if (ltdHit) newW = diff[W_WIDTH] ? '0 : diff[W_WIDTH-1:0];
        else        newW = sum[W_WIDTH]  ? '1 : sum[W_WIDTH-1:0];
        magExt = {1'b0, curMag};
        dtOut  = ltdHit ? -magExt : magExt;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ch             <= '0;
            bus.upd_valid  <= 1'b0;
            bus.upd_ch     <= '0;
            bus.upd_dt     <= '0;
            bus.upd_weight <= '0;
            for (int i = 0; i < N_PRE; i++) weight[i] <= W_WIDTH'(W_INIT);
        end else begin
            ch            <= (state == IDLE) ? '0 : ch + 1'b1;
            bus.upd_valid <= ltpHit | ltdHit;
            if (ltpHit || ltdHit) begin
                weight[ch]     <= newW;
                bus.upd_ch     <= ch;
                bus.upd_dt     <= dtOut;
                bus.upd_weight <= newW;
            end
        end
    end

    assign bus.rd_weight = weight[bus.rd_sel];
    assign bus.busy      = (state != IDLE);

endmodule
